// File: rtl/noise_poly_add_if.sv
// Stream and control bundle between the noise sampler/source and noise_poly_add.
interface noise_poly_add_if #(
    parameter int unsigned N       = 256,
    parameter int unsigned COEFF_W = 12,
    parameter int unsigned NOISE_W = 4
);
    logic                   start;
    logic [N*NOISE_W-1:0]   noise;
    logic [COEFF_W-1:0]     in_coeff;
    logic                   in_valid;
    logic                   in_ready;
    logic [COEFF_W-1:0]     out_coeff;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, noise, in_coeff, in_valid, out_ready,
        input  in_ready, out_coeff, out_valid, busy, done, err
    );

    modport slave (
        input  start, noise, in_coeff, in_valid, out_ready,
        output in_ready, out_coeff, out_valid, busy, done, err
    );
endinterface

// File: rtl/noise_poly_add.sv
// Adds a latched 256-coefficient CBD noise polynomial, mod q, to a coefficient stream.
module noise_poly_add #(
    parameter int unsigned N       = 256,
    parameter int unsigned Q       = 3329,
    parameter int unsigned COEFF_W = 12,
    parameter int unsigned NOISE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    noise_poly_add_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(N) + 1;
    localparam int unsigned SUM_W = COEFF_W + 2;
    localparam int unsigned NZ_W  = N * NOISE_W;

    localparam logic signed [SUM_W-1:0] Q_S  = SUM_W'(Q);
    localparam logic signed [SUM_W-1:0] E_HI = SUM_W'(2);
    localparam logic signed [SUM_W-1:0] E_LO = -SUM_W'(2);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state_q, state_d;
    logic [NZ_W-1:0]      noise_q, noise_d;
    logic [IDX_W-1:0]     in_idx_q, in_idx_d;
    logic [IDX_W-1:0]     out_cnt_q, out_cnt_d;
    logic [COEFF_W-1:0]   out_coeff_q, out_coeff_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 in_ready_c;
    logic                 in_xfer_c;
    logic                 out_xfer_c;
    logic signed [SUM_W-1:0] e_ext_c;
    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] red_c;
    logic                 nib_bad_c;
    logic                 coeff_bad_c;

    // Handshake: single output register, input only when it is free or draining.
    always_comb begin
        in_ready_c  = (state_q == RUN) && (in_idx_q < IDX_W'(N)) &&
                      (!out_valid_q || bus.out_ready);
        in_xfer_c   = in_ready_c && bus.in_valid;
        out_xfer_c  = (state_q == RUN) && out_valid_q && bus.out_ready;
    end

    // Datapath: sign-extend the current nibble, add, one conditional correction.
    always_comb begin
        e_ext_c     = {{(SUM_W-NOISE_W){noise_q[NOISE_W-1]}}, noise_q[NOISE_W-1:0]};
        sum_c       = {2'b00, bus.in_coeff} + e_ext_c;
        red_c       = sum_c;
        if (sum_c[SUM_W-1]) begin
            red_c = sum_c + Q_S;
        end else if (sum_c >= Q_S) begin
            red_c = sum_c - Q_S;
        end
        nib_bad_c   = (e_ext_c < E_LO) || (e_ext_c > E_HI);
        coeff_bad_c = (bus.in_coeff >= COEFF_W'(Q));
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        noise_d     = noise_q;
        in_idx_d    = in_idx_q;
        out_cnt_d   = out_cnt_q;
        out_coeff_d = out_coeff_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    noise_d     = bus.noise;
                    in_idx_d    = '0;
                    out_cnt_d   = '0;
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (out_xfer_c) begin
                    out_valid_d = 1'b0;
                    out_cnt_d   = out_cnt_q + IDX_W'(1);
                end
                if (in_xfer_c) begin
                    out_coeff_d = COEFF_W'(red_c);
                    out_valid_d = 1'b1;
                    noise_d     = noise_q >> NOISE_W;
                    in_idx_d    = in_idx_q + IDX_W'(1);
                    if (nib_bad_c || coeff_bad_c) begin
                        err_d = 1'b1;
                    end
                end
                if (out_xfer_c && (out_cnt_q == IDX_W'(N - 1))) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noise_q     <= '0;
            in_idx_q    <= '0;
            out_cnt_q   <= '0;
            out_coeff_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            noise_q     <= noise_d;
            in_idx_q    <= in_idx_d;
            out_cnt_q   <= out_cnt_d;
            out_coeff_q <= out_coeff_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_coeff = out_coeff_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_noise_poly_add.sv
// Scoreboard bench for noise_poly_add: driver pushes expected sums, monitor pops on transfers.
module tb_noise_poly_add;
    localparam int N = 256;
    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    noise_poly_add_if bus ();

    noise_poly_add dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [11:0]    exp_q[$];
    int             out_cnt      = 0;
    int             last_out_cyc = 0;
    bit             hold_pend    = 1'b0;
    logic [11:0]    hold_val     = '0;

    logic [11:0]    coeff_v[N];
    logic [11:0]    exp_v[N];
    logic [1023:0]  noise_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] golden(input int c, input logic [3:0] nib);
        int e;
        int r;
        e = nib[3] ? int'(nib) - 16 : int'(nib);
        r = c + e;
        if (r < 0) r += Q;
        else if (r >= Q) r -= Q;
        return 12'(r);
    endfunction

    // Monitor: compare every output transfer against the scoreboard; check stall stability.
    always @(negedge clk) begin
        if (rst) begin
            if (hold_pend) begin
                check("stall_valid_held", 32'(bus.out_valid), 32'd1);
                check("stall_coeff_held", 32'(bus.out_coeff), 32'(hold_val));
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_val  = bus.out_coeff;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra: output %0d with nothing expected", bus.out_coeff);
                end else begin
                    check("sb_data", 32'(bus.out_coeff), 32'(exp_q.pop_front()));
                end
                last_out_cyc = cyc;
                out_cnt++;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // One full run: latch noise_v, stream coeff_v, optionally abort after abort_at outputs.
    task automatic run_test(input bit stall, input bit restart_mid, input int abort_at,
                            input bit exp_err);
        int idx   = 0;
        int base  = out_cnt;
        int acc0  = -1;
        int fo    = -1;
        int extra = 0;
        bit fin   = 1'b0;
        bit abort = 1'b0;
        exp_q.delete();
        bus.noise = noise_v;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("err_cleared_on_start", 32'(bus.err), 32'd0);
        for (int c = 0; c < 4000 && !fin && !abort; c++) begin
            if (idx < N) begin
                bus.in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                bus.in_coeff = coeff_v[idx];
            end else begin
                bus.in_valid = 1'b1;
                bus.in_coeff = 12'd5;
            end
            bus.out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (restart_mid && c == 40) begin
                bus.start = 1'b1;
                bus.noise = {256{4'hF}};
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk); #1;
            if (bus.in_valid && bus.in_ready) begin
                if (idx < N) begin
                    exp_q.push_back(exp_v[idx]);
                    if (idx == 0) acc0 = cyc;
                    idx++;
                end else begin
                    extra++;
                end
            end
            if (fo < 0 && out_cnt - base > 0) fo = last_out_cyc;
            if (bus.done) fin = 1'b1;
            if (abort_at > 0 && out_cnt - base >= abort_at) abort = 1'b1;
            if (!fin && !abort) begin
                @(posedge clk); #1;
            end
        end
        bus.start = 1'b0;
        if (abort) begin
            #1 rst = 1'b0;
            #1;
            check("abort_out_valid", 32'(bus.out_valid), 32'd0);
            check("abort_out_coeff", 32'(bus.out_coeff), 32'd0);
            check("abort_busy", 32'(bus.busy), 32'd0);
            check("abort_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b0;
            exp_q.delete();
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); #1;
                check("abort_no_done", 32'(bus.done), 32'd0);
            end
            rst = 1'b1;
            @(posedge clk); #1;
            check("abort_idle_done", 32'(bus.done), 32'd0);
        end else begin
            check("done_seen", 32'(fin), 32'd1);
            check("busy_at_done", 32'(bus.busy), 32'd0);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("done_one_cycle", 32'(bus.done), 32'd0);
            check("out_transfers", 32'(out_cnt - base), 32'(N));
            check("sb_drained", 32'(exp_q.size()), 32'd0);
            check("extra_in_ignored", 32'(extra), 32'd0);
            check("err_flag", 32'(bus.err), 32'(exp_err));
            if (!stall) begin
                check("first_latency", 32'(fo - acc0), 32'd1);
                check("full_throughput", 32'(last_out_cyc - fo), 32'(N - 1));
            end
            repeat (3) @(posedge clk);
            #1 check("err_holds_idle", 32'(bus.err), 32'(exp_err));
        end
    endtask

    task automatic load_plus_one();
        for (int i = 0; i < N; i++) begin
            noise_v[4*i +: 4] = 4'h1;
            coeff_v[i]        = 12'(i);
            exp_v[i]          = 12'(i + 1);
        end
    endtask

    initial begin
        logic [3:0] pat[5];
        pat = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
        bus.start     = 1'b0;
        bus.noise     = '0;
        bus.in_coeff  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset and idle behaviour.
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_coeff", 32'(bus.out_coeff), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            check("idle_in_ready", 32'(bus.in_ready), 32'd0);
            check("idle_out_valid", 32'(bus.out_valid), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_done", 32'(bus.done), 32'd0);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;

        // Basic +1 sum at full rate.
        load_plus_one();
        run_test(1'b0, 1'b0, 0, 1'b0);

        // Wrap cases, bad nibble, out-of-range coeff, ignored second start.
        for (int i = 0; i < N; i++) begin
            noise_v[4*i +: 4] = 4'h0;
            coeff_v[i]        = 12'(i);
            exp_v[i]          = 12'(i);
        end
        noise_v[3:0]   = 4'hE; coeff_v[0] = 12'd1;    exp_v[0] = 12'd3328;
        noise_v[7:4]   = 4'h2; coeff_v[1] = 12'd3328; exp_v[1] = 12'd1;
        noise_v[11:8]  = 4'hF; coeff_v[2] = 12'd0;    exp_v[2] = 12'd3328;
        noise_v[15:12] = 4'h0; coeff_v[3] = 12'd3328; exp_v[3] = 12'd3328;
        noise_v[23:20] = 4'h7; coeff_v[5] = 12'd3325; exp_v[5] = 12'd3;
        noise_v[27:24] = 4'h0; coeff_v[6] = 12'd3400; exp_v[6] = 12'd71;
        run_test(1'b0, 1'b1, 0, 1'b1);

        // Random backpressure and input gaps over a mixed in-range pattern.
        for (int i = 0; i < N; i++) begin
            noise_v[4*i +: 4] = pat[i % 5];
            coeff_v[i]        = 12'((i * 13 + 3300) % Q);
            exp_v[i]          = golden(int'(coeff_v[i]), pat[i % 5]);
        end
        run_test(1'b1, 1'b0, 0, 1'b0);

        // Reset mid-run after 100 outputs, then a clean full run.
        load_plus_one();
        run_test(1'b0, 1'b0, 100, 1'b0);
        run_test(1'b0, 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noise_poly_add.md
Name: noise_poly_add

Overview:
- Downstream consumer of the noise sampler (CBD output): latches one packed 256-coefficient noise polynomial, coefficients in [-2,2].
- Adds the noise coefficient-wise, mod q, to a 12-bit coefficient stream (e.g. u = A^T·r, or v before message add).
- Emits the sum as a valid/ready stream, then pulses done.
- Sits between the noise generator and the ciphertext compress/encode stage in encapsulation.

Parameters:
- N, 256, coefficients per polynomial
- Q, 3329, modulus
- COEFF_W, 12, stream coefficient width
- NOISE_W, 4, packed noise coefficient width (two's complement)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; latch noise (driven by sampler done)
- noise  input  N*NOISE_W (1024)  packed noise; coeff i at bits [4i+3:4i], signed
- in_coeff  input  COEFF_W  input coefficient, expected in [0,Q-1]
- in_valid  input  1  in_coeff valid
- in_ready  output  1  block accepts in_coeff this cycle
- out_coeff  output  COEFF_W  (in_coeff + noise_i) mod Q
- out_valid  output  1  out_coeff valid
- out_ready  input  1  downstream accepts out_coeff
- busy  output  1  high from start accept until done
- done  output  1  one-cycle pulse after last output transfer
- err  output  1  sticky: bad noise nibble or in_coeff >= Q seen this run

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready=0, out_valid=0, out_coeff=0, busy=0, done=0, err=0; counters and noise register cleared. Reset mid-run aborts the run; no done is issued.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 → latch noise into a 1024-bit shift register, in_idx=0, out_cnt=0, err=0, busy=1, go to RUN next cycle.
  - start in any other state is ignored.
- RUN:
  - in_ready = (in_idx < N) && (!out_valid || out_ready): one-entry output register, no skid buffer.
  - Input transfer = in_valid && in_ready.
  - On input transfer:
    - e = sign-extended low nibble; r = in_coeff + e (signed, 14 bits).
    - If r < 0, r += Q; else if r >= Q, r -= Q.
    - out_coeff <= r[11:0]; out_valid <= 1.
    - Shift noise register right by 4; in_idx++.
  - Output transfer = out_valid && out_ready: out_cnt++. out_valid clears unless a new input transfers the same cycle.
  - Latency: input transfer at cycle t → out_valid at t+1. Full throughput of 1 coeff/cycle when out_ready is held high.
  - After in_idx reaches N, in_ready stays 0 and extra in_valid is ignored.
  - The output transfer that brings out_cnt to N moves the FSM to FIN.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE. err holds until the next start.
- err set when:
  - a noise nibble is outside [-2,2] (0x3..0x7, 0x8..0xD); the value is still added as signed.
  - in_coeff >= Q on transfer; single conditional subtract only, out_coeff = r - Q (no further reduction).
- Backpressure: out_ready=0 holds out_coeff/out_valid stable and stalls input (in_ready=0). Nothing is lost or duplicated.
- Simultaneous output transfer and input transfer in RUN: both take effect; the register is reloaded and out_valid stays 1.

Test Plan:
- Reset/idle: rst=0 then 1, no start → in_ready=0, out_valid=0, done=0, busy=0 indefinitely.
- Basic sum: noise all 0x1 (+1), in_coeff = 0..255, out_ready=1 → outputs 1..256 on 256 consecutive cycles, first at 1 cycle after first accept, done pulses once, err=0.
- Wrap both ways:
  - nibble0=0xE (-2), in_coeff0=1 → 3328.
  - nibble1=0x2, in_coeff1=3328 → 1.
  - nibble2=0xF, in_coeff2=0 → 3328.
  - nibble3=0x0, in_coeff3=3328 → 3328.
- Backpressure: random out_ready (~50%), random in_valid gaps → output sequence identical to the no-stall golden model, exactly 256 transfers, out_coeff stable while stalled.
- Errors/ignores:
  - nibble5=0x7 → err=1 by end; output = (in_coeff5+7) mod-reduced once.
  - in_coeff=3400 with e=0 → out=71, err=1.
  - A second start mid-RUN is ignored and the noise is unchanged.
- Reset mid-run: deassert rst after 100 outputs → outputs cleared immediately, no done. A new start then runs all 256 coefficients from index 0.
